io_frame_scheduler: RTL and testbench
=====================================

# io_frame_scheduler

Sequences the board-to-host status path of the UART-emulated DE1SoC. It snapshots the LED and six 7-segment display inputs and builds a 10-byte status frame with a header and XOR checksum. It feeds the frame byte-by-byte to the UART transmitter over a valid/ready handshake. A frame is sent when any input changes, on a periodic refresh, and once after reset.

## Interface
- `clock`, default 50000000: i_CLK frequency in Hz.
- `refresh_hz`, default 20: forced-refresh rate. Refresh period is `REFRESH_CYCLES = clock/refresh_hz`.
- `header`, default 8'hA5: first byte of every frame.

- `i_CLK`, in, 1: the single clock. All logic is on the rising edge.
- `i_RST`, in, 1: reset, asynchronous and active-low.
- `i_LEDS`, in, 10: live LED state.
- `i_7S5` … `i_7S0`, in, 7 each: live segment patterns for displays 5 down to 0.
- `i_TX_READY`, in, 1: the transmitter accepts a byte this cycle.
- `o_TX_DATA`, out, 8: byte currently offered to the transmitter.
- `o_TX_VALID`, out, 1: `o_TX_DATA` is valid.
- `o_BUSY`, out, 1: a frame is in progress.
- `o_FRAME_DONE`, out, 1: one-cycle pulse after the last byte is accepted.

## Operation
- Frame byte order, indices 0–9:
  - 0: `header`
  - 1: `i_LEDS[7:0]`
  - 2: `{6'b0, i_LEDS[9:8]}`
  - 3–8: `{1'b0, i_7S5}` through `{1'b0, i_7S0}`
  - 9: checksum, the XOR of bytes 1–8 (the header is excluded).
- All frame bytes come from a 52-bit snapshot. The snapshot is captured in the trigger cycle.
- Inputs that change during a frame do not affect that frame. The change is picked up in IDLE after the frame completes.
- A second register holds the last-sent value, updated at frame completion.
- Trigger conditions, evaluated only in IDLE; any one of them starts a frame:
  - live inputs differ from the last-sent value;
  - the refresh counter equals `REFRESH_CYCLES-1`;
  - the force flag is set. The force flag is set by reset and cleared when a frame starts.
- State machine:
  - IDLE → SEND on a trigger. Capture the snapshot, set byte index to 0, clear the force flag.
  - SEND: on a handshake (`o_TX_VALID && i_TX_READY`), advance the index.
  - SEND → DONE on a handshake at index 9.
  - DONE → IDLE unconditionally. `o_FRAME_DONE` is high for this cycle, the last-sent value is updated, and the refresh counter is cleared.
- Refresh counter: increments only in IDLE, saturates at `REFRESH_CYCLES-1`, and clears in DONE.
- Handshake rules:
  - Once `o_TX_VALID` rises it stays high until the byte is accepted.
  - `o_TX_DATA` is stable while `o_TX_VALID && !i_TX_READY`.
  - `o_TX_VALID` never depends combinationally on `i_TX_READY`.
- Reset asserted mid-frame: the frame is aborted immediately with no done pulse. After release, a full frame is sent via the force flag.

## Timing
- Reset values:
  - `o_TX_DATA` = 8'h00; `o_TX_VALID`, `o_BUSY` and `o_FRAME_DONE` = 0.
  - State IDLE, index 0, refresh counter 0, force flag 1.
  - Snapshot and last-sent registers all 0.
- Trigger in IDLE at cycle N:
  - `o_TX_VALID` = 1 and `o_TX_DATA = header` at N+1.
  - `o_BUSY` = 1 from N+1 through the DONE cycle.
- Handshake at cycle M, index k<9: the byte at index k+1 is presented at M+1 with `o_TX_VALID` still high. With `i_TX_READY` tied high, consecutive bytes go out back-to-back, one per cycle.
- Handshake at index 9 at cycle M:
  - `o_TX_VALID` = 0 at M+1;
  - `o_FRAME_DONE` = 1 at M+1 only;
  - IDLE at M+2;
  - earliest next header at M+3.
- Minimum frame duration with ready tied high: 10 cycles of valid plus 2 cycles of gap.
- First frame after reset release: header appears on the second rising edge after release.

## Structure
- Package `io_frame_pkg`:
  - `FRAME_LEN` = 10
  - `IDX_W` = 4
  - `st_t` state enum: IDLE, SEND, DONE
  - `HDR_DEFAULT` = 8'hA5
  - a function computing the byte for a given index.
- Sub-module `io_frame_timer`: the saturating refresh counter. Inputs: enable, clear. Output: expired.
- The FSM, snapshot registers and byte mux stay in `io_frame_scheduler`.

## Test plan
- Reset release with `i_TX_READY`=1 and all inputs 0 → bytes A5,00,00,00,00,00,00,00,00,00 back-to-back, then one `o_FRAME_DONE` pulse.
- `i_LEDS`=10'h3FF, all `i_7S`=7'h7F → frame A5,FF,03,7F,7F,7F,7F,7F,7F,FC.
- `i_LEDS`=10'h155, `i_7S5`=7'h40, others 0; `i_TX_READY` toggling 1-in-3 → frame A5,55,01,40,00,00,00,00,00,14. Data must stay stable on every stalled cycle.
- Change `i_LEDS` mid-frame → the current frame carries the old value, and a second frame with the new value follows immediately after DONE.
- Static inputs with `clock`=1000, `refresh_hz`=100 → a frame every 10 IDLE cycles plus frame time, identical contents each time.
- `i_RST` low at byte 5, held for 3 cycles → `o_TX_VALID` and `o_BUSY` drop immediately, no `o_FRAME_DONE`; a full frame restarts after release.

Source files
------------

// File: rtl/io_frame_pkg.sv
// Shared types and frame layout for the board-to-host status frame.
// Snapshot layout (52 bits): {leds[9:0], s5, s4, s3, s2, s1, s0}.
package io_frame_pkg;

    localparam int FRAME_LEN = 10;
    localparam int IDX_W     = 4;
    localparam int SNAP_W    = 52;
    localparam logic [7:0]       HDR_DEFAULT = 8'hA5;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } st_t;

    function automatic logic [7:0] frame_byte(input logic [7:0]        hdr,
                                              input logic [SNAP_W-1:0] snap,
                                              input logic [IDX_W-1:0]  idx);
        logic [FRAME_LEN-1:0][7:0] b;
        logic [7:0] ck;
        b    = '0;
        b[0] = hdr;
        b[1] = snap[49:42];
        b[2] = {6'b0, snap[51:50]};
        for (int i = 0; i < 6; i++)
            b[3+i] = {1'b0, snap[41-7*i -: 7]};
        // header is deliberately left out of the checksum
        ck = 8'h00;
        for (int i = 1; i <= 8; i++)
            ck ^= b[i];
        b[9] = ck;
        return (idx < IDX_W'(FRAME_LEN)) ? b[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/io_frame_timer.sv
// Saturating refresh counter; expired holds once the period has elapsed.
module io_frame_timer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/io_frame_scheduler.sv
// Snapshots LEDs and 7-segment inputs and streams a 10-byte status frame
// (header, payload, XOR checksum) to the UART transmitter over valid/ready.
module io_frame_scheduler
    import io_frame_pkg::*;
#(
    parameter int         clock      = 50000000,
    parameter int         refresh_hz = 20,
    parameter logic [7:0] header     = HDR_DEFAULT
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [9:0] i_LEDS,
    input  logic [6:0] i_7S5,
    input  logic [6:0] i_7S4,
    input  logic [6:0] i_7S3,
    input  logic [6:0] i_7S2,
    input  logic [6:0] i_7S1,
    input  logic [6:0] i_7S0,
    input  logic       i_TX_READY,
    output logic [7:0] o_TX_DATA,
    output logic       o_TX_VALID,
    output logic       o_BUSY,
    output logic       o_FRAME_DONE
);

    localparam int REFRESH_CYCLES = clock / refresh_hz;

    st_t               state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [SNAP_W-1:0] live, snap, last_sent;
    logic              force_flag;
    logic              expired;
    logic              trigger;
    logic              hs;

    assign live    = {i_LEDS, i_7S5, i_7S4, i_7S3, i_7S2, i_7S1, i_7S0};
    assign hs      = o_TX_VALID && i_TX_READY;
    assign trigger = (live != last_sent) || expired || force_flag;

    io_frame_timer #(
        .CYCLES (REFRESH_CYCLES)
    ) u_timer (
        .clk     (i_CLK),
        .rst_n   (i_RST),
        .en      (state == IDLE),
        .clr     (state == DONE),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = SEND;
            SEND:    if (hs && idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state      <= IDLE;
            idx        <= '0;
            force_flag <= 1'b1;
            snap       <= '0;
            last_sent  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (trigger) begin
                    snap       <= live;
                    idx        <= '0;
                    force_flag <= 1'b0;
                end
                SEND: if (hs && idx != LAST_IDX) idx <= idx + 1'b1;
                DONE: last_sent <= snap;
                default: ;
            endcase
        end
    end

    // Data is a pure function of registered snapshot/index, so it holds across stalls.
    assign o_TX_VALID   = (state == SEND);
    assign o_TX_DATA    = o_TX_VALID ? frame_byte(header, snap, idx) : 8'h00;
    assign o_BUSY       = (state != IDLE);
    assign o_FRAME_DONE = (state == DONE);

endmodule

// File: tb/tb_io_frame_scheduler.sv
// Randomized bench for io_frame_scheduler with a frame-level reference model.
module tb_io_frame_scheduler;

    localparam int R = 10;  // clock/refresh_hz of the instance below

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [9:0]      leds = '0;
    logic [5:0][6:0] seg = '0;
    logic            ready = 1'b1;
    logic [7:0]      tx_data;
    logic            tx_valid, busy, frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    io_frame_scheduler #(.clock(1000), .refresh_hz(100), .header(8'hA5)) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_LEDS(leds),
        .i_7S5(seg[5]), .i_7S4(seg[4]), .i_7S3(seg[3]),
        .i_7S2(seg[2]), .i_7S1(seg[1]), .i_7S0(seg[0]),
        .i_TX_READY(ready), .o_TX_DATA(tx_data), .o_TX_VALID(tx_valid),
        .o_BUSY(busy), .o_FRAME_DONE(frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    int              mcyc = 0;
    int              frames = 0;
    int              done_cyc = 0, hdr_cyc = 0;
    logic [7:0]      last_frame [10];
    logic [7:0]      fb [10];
    int              nbytes = 0;
    bit              m_force = 1, in_frame = 0, done_due = 0, just_done = 0;
    bit              have_pend = 0, pend_trig = 0, stall = 0;
    logic [7:0]      stall_data;
    int              m_idle = 0;
    logic [51:0]     m_last = '0;
    logic [9:0]      pend_leds, exp_leds;
    logic [5:0][6:0] pend_seg, exp_seg;

    initial forever begin
        @(negedge clk);
        mcyc++;
        if (!rst_n) begin
            chk("rst_valid", tx_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_data", tx_data, 0);
            m_force = 1; m_last = '0; m_idle = 0; have_pend = 0; in_frame = 0;
            nbytes = 0; stall = 0; done_due = 0; just_done = 0;
        end else begin
            if (have_pend) begin
                chk("start", busy, pend_trig);
                if (pend_trig) begin
                    in_frame = 1; nbytes = 0; m_force = 0;
                    exp_leds = pend_leds; exp_seg = pend_seg; hdr_cyc = mcyc;
                    chk("hdr_valid", tx_valid, 1);
                    chk("hdr_data", tx_data, 8'hA5);
                end else
                    m_idle++;
                have_pend = 0;
            end
            if (stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, stall_data);
            end
            stall = 0;
            just_done = 0;
            if (done_due) begin
                logic [7:0] e [10];
                e[0] = 8'hA5;
                e[1] = exp_leds[7:0];
                e[2] = {6'b0, exp_leds[9:8]};
                for (int d = 5; d >= 0; d--) e[8-d] = {1'b0, exp_seg[d]};
                e[9] = e[1] ^ e[2] ^ e[3] ^ e[4] ^ e[5] ^ e[6] ^ e[7] ^ e[8];
                chk("done", frame_done, 1);
                chk("done_valid", tx_valid, 0);
                chk("done_busy", busy, 1);
                for (int i = 0; i < 10; i++) begin
                    chk($sformatf("byte%0d", i), fb[i], e[i]);
                    last_frame[i] = fb[i];
                end
                m_last = {exp_leds, exp_seg};
                m_idle = 0; done_due = 0; just_done = 1;
                done_cyc = mcyc;
                frames++;
            end else
                chk("no_done", frame_done, 0);
            if (in_frame) begin
                if (tx_valid && ready) begin
                    fb[nbytes] = tx_data;
                    nbytes++;
                    if (nbytes == 10) begin
                        done_due = 1; in_frame = 0;
                    end
                end else if (tx_valid) begin
                    stall = 1; stall_data = tx_data;
                end
            end else if (!done_due && !just_done) begin
                chk("idle_busy", busy, 0);
                pend_trig = m_force || ({leds, seg} != m_last) || (m_idle == R - 1);
                pend_leds = leds; pend_seg = seg;
                have_pend = 1;
            end
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        int rc = 0;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = (rc % 3 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int start = frames;
        int c = 0;
        while (frames < start + n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("frame_timeout", frames - start >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            step(1);
            c++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_busy(input int budget);
        int c = 0;
        while (!busy && c < budget) begin
            step(1);
            c++;
        end
        chk("busy_timeout", busy, 1);
    endtask

    task automatic chk_frame(input string tag, input logic [79:0] exp);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_b%0d", tag, i), last_frame[i], exp[79-8*i -: 8]);
    endtask

    initial begin
        int fr0, d1;
        step(3);
        rst_n = 1'b1;
        wait_frames(1, 40);
        chk_frame("zero", 80'hA5_00_00_00_00_00_00_00_00_00);

        wait_idle(40);
        leds = 10'h3FF;
        for (int i = 0; i < 6; i++) seg[i] = 7'h7F;
        wait_frames(1, 60);
        chk_frame("ones", 80'hA5_FF_03_7F_7F_7F_7F_7F_7F_FC);

        ready_mode = 1;
        wait_idle(80);
        leds = 10'h155;
        seg = '0;
        seg[5] = 7'h40;
        wait_frames(1, 120);
        chk_frame("stall", 80'hA5_55_01_40_00_00_00_00_00_14);
        ready_mode = 0;

        wait_idle(80);
        leds = 10'h0AA;
        wait_busy(5);
        step(3);
        leds = 10'h2CC;
        wait_frames(1, 40);
        chk("mid_old_b1", last_frame[1], 8'hAA);
        chk("mid_old_b2", last_frame[2], 8'h00);
        d1 = done_cyc;
        wait_frames(1, 40);
        chk("mid_new_b1", last_frame[1], 8'hCC);
        chk("mid_new_b2", last_frame[2], 8'h02);
        chk("mid_gap", hdr_cyc - d1, 2);

        for (int k = 0; k < 2; k++) begin
            d1 = done_cyc;
            wait_frames(1, 60);
            chk("refresh_period", done_cyc - d1, 21);
        end

        wait_idle(40);
        wait_busy(20);
        step(5);
        fr0 = frames;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        step(3);
        rst_n = 1'b1;
        wait_frames(1, 40);
        chk("abort_frames", frames, fr0 + 1);

        ready_mode = 2;
        for (int it = 0; it < 600; it++) begin
            step(1);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) leds = 10'($urandom);
                else seg[$urandom_range(0, 5)] = 7'($urandom);
            end
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
        end
        ready_mode = 0;
        wait_frames(1, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
